fp_add_scheduler: RTL and testbench

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

---
 rtl/fp_sched_pkg.sv | 20 ++
 rtl/fp_add_scheduler_if.sv | 31 +++
 rtl/fp_add_scheduler_arb.sv | 30 +++
 rtl/fp_add_scheduler.sv | 128 ++++++++++++
 tb/tb_fp_add_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types for the FP adder scheduler: slot states and the tag carried
// alongside each operation through the adder latency.
package fp_sched_pkg;

    localparam int FP_WIDTH = 32;
    // Wide enough for the largest supported requester count (8)
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IN_FLIGHT = 2'd1,
        DONE      = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Request/response/adder bus of the FP adder scheduler.
// master = requesters plus the external adder; slave = the scheduler.
interface fp_add_scheduler_if
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = FP_WIDTH
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [NUM_REQ*WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0]         add_in1;
    logic [WIDTH-1:0]         add_in2;
    logic [WIDTH-1:0]         add_out;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_out,
        input  req_ready, rsp_valid, rsp_data, add_in1, add_in2
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_out,
        output req_ready, rsp_valid, rsp_data, add_in1, add_in2
    );

endinterface

// File: rtl/fp_add_scheduler_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer, and the pointer value that follows that grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_next_ptr
);

    logic [PTR_W-1:0] w_pos;

    // Walk offsets from farthest to nearest so the requester closest to the pointer wins
    always_comb begin
        o_grant    = '0;
        o_next_ptr = i_ptr;
        w_pos      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = PTR_W'((int'(i_ptr) + k) % N);
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_next_ptr     = PTR_W'((int'(w_pos) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one external pipelined FP adder among NUM_REQ requesters.
// Each requester owns one slot; a tag pipeline matching the adder latency
// tells which slot captures add_out. Sum bits are never inspected.
//
// state     | meaning
// IDLE      | slot free, requester may be granted
// IN_FLIGHT | operation issued, tag still travelling down the pipeline
// DONE      | result held in rsp_data, waiting for rsp_ready
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 2,
    parameter int WIDTH   = FP_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_add_scheduler_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    slot_state_t        r_slot     [NUM_REQ];
    tag_t               r_tag      [ADD_LAT+1];
    logic [WIDTH-1:0]   r_rsp_data [NUM_REQ];
    logic [PTR_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_add_in1;
    logic [WIDTH-1:0]   r_add_in2;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_issue;

    // A requester competes only while presenting work with its slot free
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] && (r_slot[i] == IDLE);
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req      (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    // Ready is held low while reset is asserted even though slots read IDLE
    assign bus.req_ready = w_grant & {NUM_REQ{rst_n}};
    assign w_issue       = |w_grant;

    // Select the granted requester's operands and index
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a   = bus.req_a[k*WIDTH +: WIDTH];
                w_sel_b   = bus.req_b[k*WIDTH +: WIDTH];
                w_sel_idx = IDX_W'(k);
            end
        end
    end

    // Slot FSMs, arbitration pointer, operand registers, tag pipeline and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_add_in1 <= '0;
            r_add_in2 <= '0;
            for (int s = 0; s <= ADD_LAT; s++) begin
                r_tag[s] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                r_slot[i]     <= IDLE;
                r_rsp_data[i] <= '0;
            end
        end else begin
            r_ptr     <= w_next_ptr;
            r_add_in1 <= w_issue ? w_sel_a : '0;
            r_add_in2 <= w_issue ? w_sel_b : '0;
            r_tag[0]  <= '{valid: w_issue, index: w_sel_idx};
            for (int s = 1; s <= ADD_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case (r_slot[i])
                    IDLE: begin
                        if (w_grant[i]) begin
                            r_slot[i] <= IN_FLIGHT;
                        end
                    end
                    IN_FLIGHT: begin
                        // Last tag stage lines up with add_out for that operation
                        if (r_tag[ADD_LAT].valid && (r_tag[ADD_LAT].index == IDX_W'(i))) begin
                            r_slot[i]     <= DONE;
                            r_rsp_data[i] <= bus.add_out;
                        end
                    end
                    DONE: begin
                        if (bus.rsp_ready[i]) begin
                            r_slot[i] <= IDLE;
                        end
                    end
                    default: r_slot[i] <= IDLE;
                endcase
            end
        end
    end

    assign bus.add_in1 = r_add_in1;
    assign bus.add_in2 = r_add_in2;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign bus.rsp_valid[g]                = (r_slot[g] == DONE);
        assign bus.rsp_data[g*WIDTH +: WIDTH]  = r_rsp_data[g];
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: behavioural pipelined FP adder plus a
// transaction-level model (round-robin pick, per-requester outstanding flag,
// result due time, expected sum).
module tb_fp_add_scheduler;

    localparam int NR  = 4;
    localparam int LAT = 2;
    localparam int W   = 32;

    logic clk;
    logic rst_n;

    fp_add_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    fp_add_scheduler #(
        .NUM_REQ (NR),
        .ADD_LAT (LAT),
        .WIDTH   (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple single-precision add: truncating, denormals flushed, Inf/NaN passed through
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [27:0] mx, my, s;
        int ex, ey, d;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        d  = ex - ey;
        mx = {2'b01, x[22:0], 3'b000};
        my = (d > 27) ? 28'd0 : ({2'b01, y[22:0], 3'b000} >> d);
        if (x[31] == y[31]) begin
            s = mx + my;
            if (s[27]) begin s = s >> 1; ex++; end
            if (ex >= 255) return {x[31], 8'hFF, 23'd0};
        end else begin
            s = mx - my;
            if (s == 28'd0) return 32'd0;
            for (int k = 0; k < 27; k++) begin
                if (!s[26]) begin s = s << 1; ex--; end
            end
            if (ex <= 0) return {x[31], 31'd0};
        end
        return {x[31], 8'(ex), s[25:3]};
    endfunction

    // External adder: LAT register stages
    logic [W-1:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= fp_add(bus.add_in1, bus.add_in2);
        for (int s = 1; s < LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
    assign bus.add_out = add_pipe[LAT-1];

    // Reference model state
    bit          m_busy [NR];
    int          m_due  [NR];
    logic [31:0] m_exp  [NR];
    int          m_ptr, m_cyc, m_idx, exp_grant;
    logic [31:0] m_in1, m_in2;
    logic [NR-1:0] exp_ready, exp_rsp_valid;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_ptr = 0;
        m_in1 = '0;
        m_in2 = '0;
    endtask

    task automatic model_eval();
        #1;
        exp_grant = -1;
        for (int k = 0; k < NR; k++) begin
            m_idx = (m_ptr + k) % NR;
            if (exp_grant < 0 && bus.req_valid[m_idx] && !m_busy[m_idx]) exp_grant = m_idx;
        end
        exp_ready = (exp_grant >= 0) ? NR'(1 << exp_grant) : '0;
        for (int i = 0; i < NR; i++) exp_rsp_valid[i] = m_busy[i] && (m_cyc >= m_due[i]);
    endtask

    task automatic model_commit();
        for (int i = 0; i < NR; i++)
            if (exp_rsp_valid[i] && bus.rsp_ready[i]) m_busy[i] = 1'b0;
        if (exp_grant >= 0) begin
            m_busy[exp_grant] = 1'b1;
            m_due[exp_grant]  = m_cyc + LAT + 2;
            m_exp[exp_grant]  = fp_add(bus.req_a[exp_grant*W +: W], bus.req_b[exp_grant*W +: W]);
            m_in1 = bus.req_a[exp_grant*W +: W];
            m_in2 = bus.req_b[exp_grant*W +: W];
            m_ptr = (exp_grant + 1) % NR;
        end else begin
            m_in1 = '0;
            m_in2 = '0;
        end
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*W +: W] = $urandom;
            bus.req_b[i*W +: W] = $urandom;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        rand_ops();
        @(negedge clk);
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset rsp_valid: got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset rsp_data: got %h want 0", bus.rsp_data); end
        n_cmp++; if ({bus.add_in1, bus.add_in2} !== 64'd0) begin n_bad++; $display("FAIL reset add_in: got %h %h want 0", bus.add_in1, bus.add_in2); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '1;
        bus.req_a[0 +: W] = 32'h3F800000;
        bus.req_b[0 +: W] = 32'h40000000;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) bus.req_valid = '0;
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL single ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL single rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            n_cmp++; if ({bus.add_in1, bus.add_in2} !== {m_in1, m_in2}) begin n_bad++; $display("FAIL single add_in c%0d: got %h %h want %h %h", c, bus.add_in1, bus.add_in2, m_in1, m_in2); end
            if (c == 0) begin n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single grant0: got %b want 0001", bus.req_ready); end end
            if (c == 1) begin n_cmp++; if ({bus.add_in1, bus.add_in2} !== 64'h3F800000_40000000) begin n_bad++; $display("FAIL single operands: got %h %h", bus.add_in1, bus.add_in2); end end
            if (c == 3) begin n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single early rsp: got %b want 0000", bus.rsp_valid); end end
            if (c == 4) begin
                n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single rsp_valid t+4: got %b want 0001", bus.rsp_valid); end
                n_cmp++; if (bus.rsp_data[0 +: W] !== 32'h40400000) begin n_bad++; $display("FAIL single sum: got %h want 40400000", bus.rsp_data[0 +: W]); end
            end
            step();
        end
    endtask

    task automatic test_all_four();
        logic [NR-1:0] granted;
        do_reset();
        granted = '0;
        rand_ops();
        bus.rsp_ready = '1;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 4'b1111 & ~granted;
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL all4 ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL all4 rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            n_cmp++; if ({bus.add_in1, bus.add_in2} !== {m_in1, m_in2}) begin n_bad++; $display("FAIL all4 add_in c%0d: got %h %h want %h %h", c, bus.add_in1, bus.add_in2, m_in1, m_in2); end
            for (int i = 0; i < NR; i++) if (exp_rsp_valid[i]) begin
                n_cmp++; if (bus.rsp_data[i*W +: W] !== m_exp[i]) begin n_bad++; $display("FAIL all4 data%0d: got %h want %h", i, bus.rsp_data[i*W +: W], m_exp[i]); end
            end
            if (c < 4) begin n_cmp++; if (bus.req_ready !== NR'(1 << c)) begin n_bad++; $display("FAIL all4 order c%0d: got %b want %b", c, bus.req_ready, NR'(1 << c)); end end
            if (c >= 4 && c < 8) begin n_cmp++; if (bus.rsp_valid !== NR'(1 << (c - 4))) begin n_bad++; $display("FAIL all4 rsp order c%0d: got %b want %b", c, bus.rsp_valid, NR'(1 << (c - 4))); end end
            step();
            granted = granted | exp_ready;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int held;
        held = 0;
        bus.req_valid = '1;
        bus.rsp_ready = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            if (c == 18) begin bus.req_valid = 4'b0010; bus.rsp_ready = '1; end
            if (c < 18) rand_ops();
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL bp ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL bp rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            n_cmp++; if ({bus.add_in1, bus.add_in2} !== {m_in1, m_in2}) begin n_bad++; $display("FAIL bp add_in c%0d: got %h %h want %h %h", c, bus.add_in1, bus.add_in2, m_in1, m_in2); end
            for (int i = 0; i < NR; i++) if (exp_rsp_valid[i]) begin
                n_cmp++; if (bus.rsp_data[i*W +: W] !== m_exp[i]) begin n_bad++; $display("FAIL bp data%0d c%0d: got %h want %h", i, c, bus.rsp_data[i*W +: W], m_exp[i]); end
            end
            if (c < 18 && exp_rsp_valid[1]) held++;
            if (c <= 18 && m_busy[1]) begin n_cmp++; if (bus.req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL bp slot1 held off c%0d: got %b want 0", c, bus.req_ready[1]); end end
            if (c == 19) begin n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp slot1 reaccept: got %b want 0010", bus.req_ready); end end
            step();
        end
        n_cmp++; if (held < 10) begin n_bad++; $display("FAIL bp hold length: got %0d cycles want >=10", held); end
        bus.req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            model_eval();
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL bp drain rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            for (int i = 0; i < NR; i++) if (exp_rsp_valid[i]) begin
                n_cmp++; if (bus.rsp_data[i*W +: W] !== m_exp[i]) begin n_bad++; $display("FAIL bp drain data%0d: got %h want %h", i, bus.rsp_data[i*W +: W], m_exp[i]); end
            end
            step();
        end
    endtask

    task automatic test_fairness();
        int last_g, n0, n2;
        last_g = -1; n0 = 0; n2 = 0;
        bus.req_valid = 4'b0101;
        bus.rsp_ready = '1;
        for (int c = 0; c < 24; c++) begin
            rand_ops();
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL fair ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL fair rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            for (int i = 0; i < NR; i++) if (exp_rsp_valid[i]) begin
                n_cmp++; if (bus.rsp_data[i*W +: W] !== m_exp[i]) begin n_bad++; $display("FAIL fair data%0d: got %h want %h", i, bus.rsp_data[i*W +: W], m_exp[i]); end
            end
            if (exp_grant >= 0) begin
                if (last_g >= 0) begin
                    n_cmp++; if (bus.req_ready !== ((last_g == 0) ? 4'b0100 : 4'b0001)) begin n_bad++; $display("FAIL fair alternate c%0d: got %b after grant %0d", c, bus.req_ready, last_g); end
                end
                last_g = exp_grant;
            end
            if (bus.req_ready == 4'b0001) n0++;
            if (bus.req_ready == 4'b0100) n2++;
            step();
        end
        n_cmp++; if (n0 < 3 || n2 < 3) begin n_bad++; $display("FAIL fair starvation: got n0=%0d n2=%0d want both >=3", n0, n2); end
        bus.req_valid = '0;
        repeat (6) step();
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] granted;
        granted = '0;
        rand_ops();
        bus.rsp_ready = '1;
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = 4'b0111 & ~granted;
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL rstmid ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            step();
            granted = granted | exp_ready;
        end
        bus.req_valid = 4'b0111;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rstmid req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstmid rsp_valid: got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL rstmid rsp_data: got %h want 0", bus.rsp_data); end
        n_cmp++; if ({bus.add_in1, bus.add_in2} !== 64'd0) begin n_bad++; $display("FAIL rstmid add_in: got %h %h want 0", bus.add_in1, bus.add_in2); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        bus.req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            model_eval();
            n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstmid ghost rsp c%0d: got %b want 0000", c, bus.rsp_valid); end
            step();
        end
        bus.req_valid = 4'b0010;
        rand_ops();
        for (int c = 0; c < 6; c++) begin
            if (c == 1) bus.req_valid = '0;
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL rstmid after ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL rstmid after rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            if (c == 4) begin
                n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL rstmid after t+4: got %b want 0010", bus.rsp_valid); end
                n_cmp++; if (bus.rsp_data[W +: W] !== m_exp[1]) begin n_bad++; $display("FAIL rstmid after data: got %h want %h", bus.rsp_data[W +: W], m_exp[1]); end
            end
            step();
        end
    endtask

    task automatic test_passthrough();
        bus.req_valid = 4'b1100;
        bus.rsp_ready = '1;
        bus.req_a[3*W +: W] = 32'h7F7FFFFF;
        bus.req_b[3*W +: W] = 32'h7F7FFFFF;
        bus.req_a[2*W +: W] = 32'h7FC00001;
        bus.req_b[2*W +: W] = 32'h3F800000;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) bus.req_valid = '0;
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL pass ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL pass rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            if (exp_rsp_valid[3]) begin n_cmp++; if (bus.rsp_data[3*W +: W] !== 32'h7F800000) begin n_bad++; $display("FAIL pass overflow: got %h want 7F800000", bus.rsp_data[3*W +: W]); end end
            if (exp_rsp_valid[2]) begin n_cmp++; if (bus.rsp_data[2*W +: W] !== 32'h7FC00001) begin n_bad++; $display("FAIL pass nan: got %h want 7FC00001", bus.rsp_data[2*W +: W]); end end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NR'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '1;
            rand_ops();
            model_eval();
            n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL rand ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_cmp++; if (bus.rsp_valid !== exp_rsp_valid) begin n_bad++; $display("FAIL rand rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp_valid); end
            n_cmp++; if ({bus.add_in1, bus.add_in2} !== {m_in1, m_in2}) begin n_bad++; $display("FAIL rand add_in c%0d: got %h %h want %h %h", c, bus.add_in1, bus.add_in2, m_in1, m_in2); end
            for (int i = 0; i < NR; i++) if (exp_rsp_valid[i]) begin
                n_cmp++; if (bus.rsp_data[i*W +: W] !== m_exp[i]) begin n_bad++; $display("FAIL rand data%0d c%0d: got %h want %h", i, c, bus.rsp_data[i*W +: W], m_exp[i]); end
            end
            step();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        m_cyc         = 0;
        model_clear();
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_passthrough();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
